dmem_req_bridge: RTL
====================

# dmem_req_bridge

Data-side request bridge between the RV core cluster and the 128-bit memory controller. It accepts one scalar load/store request at a time from the core (byte/half/word with funct3-style size code), turns it into a single 16-byte-line transaction with a byte mask on a valid/ready bus, and returns sign- or zero-extended load data. While a transaction is outstanding it holds the core stalled through `o_busy`.

## Interface
Parameters:
- `ADDR_W`, 32: core and memory byte-address width.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_X`  in  1  reset; asynchronous, active-low.
- `i_req`  in  1  core request strobe; sampled only in IDLE.
- `i_we`  in  1  1 = store, 0 = load.
- `i_addr`  in  ADDR_W  byte address.
- `i_wdata`  in  32  store data, right-aligned.
- `i_ctrl`  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are illegal.
- `o_busy`  out  1  core stall.
- `o_rvalid`  out  1  one-cycle load-data-valid pulse.
- `o_rdata`  out  32  extended load data.
- `o_fault`  out  1  one-cycle pulse: misaligned access or illegal `i_ctrl`.
- `o_mem_valid`  out  1  memory request valid.
- `i_mem_ready`  in  1  memory request accept.
- `o_mem_we`  out  1  memory write.
- `o_mem_addr`  out  ADDR_W  line address; bits [3:0] = 0.
- `o_mem_wdata`  out  128  store data replicated into the addressed lane.
- `o_mem_wmask`  out  16  byte enables; 0 for reads.
- `i_mem_rvalid`  in  1  read data valid.
- `i_mem_rdata`  in  128  read line.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `i_req`=1 and the request is legal: latch `i_we`, `i_addr`, `i_ctrl`, `i_wdata`, then go to REQ.
  - If `i_req`=1 and the request is illegal: pulse `o_fault` in the next cycle and stay in IDLE. No memory transaction is issued.
  - Illegal means H/HU with `addr[0]`=1, W with `addr[1:0]`≠0, or a reserved `i_ctrl` code.
- **REQ**
  - `o_mem_valid`=1. All `o_mem_*` outputs are stable until `i_mem_ready`=1.
  - On the handshake, a store goes to DONE and a load goes to WAIT.
- **WAIT**
  - On `i_mem_rvalid`=1: select the lane at `addr[3:0]`, extend it, register it into `o_rdata`, then go to DONE.
  - `i_mem_rvalid` is ignored in every other state.
- **DONE**
  - `o_rvalid`=1 for loads only; then go to IDLE.
- Lane and mask generation:
  - B: mask = 1<<addr[3:0], wdata byte replicated ×16.
  - H: mask = 3<<addr[3:0], halfword replicated ×8.
  - W: mask = 0xF<<addr[3:0], word replicated ×4.
- Load extension: B and H are sign-extended; BU and HU are zero-extended.
- `o_rdata` holds its value until the next completed load.
- `o_busy` = (IDLE & `i_req` & legal) | REQ | WAIT. This is combinational on `i_req`, so the core stalls in the same cycle it issues. `o_busy` is low in DONE.

## Timing
- Reset values: state IDLE; `o_busy`, `o_rvalid`, `o_fault`, `o_mem_valid`, `o_mem_we` all 0; `o_mem_addr`, `o_mem_wdata`, `o_mem_wmask`, `o_rdata` all 0.
- Best-case load (ready and rvalid each at the earliest legal cycle):
  - cycle 0 accept
  - cycle 1 REQ + ready
  - cycle 2 WAIT + rvalid
  - cycle 3 `o_rvalid`
  - cycle 4 next accept possible
- Best-case store: cycle 0 accept, cycle 1 handshake, cycle 2 DONE, cycle 3 next accept.
- No limit on ready or rvalid wait; no timeout.
- `i_mem_rvalid` in the same cycle as the REQ handshake is illegal for the memory side and is ignored by this block.
- Reset mid-transaction: asynchronous return to IDLE, `o_mem_valid` drops immediately, and any late `i_mem_rvalid` is ignored. The memory controller tolerates abandoned requests.
- `i_req` while not in IDLE is ignored. The core does not issue while `o_busy`=1.

## Test plan
- **LB sign-extension:** LB at 0x8000_0005 with line byte5=0x80 → `o_mem_addr`=0x8000_0000, `o_mem_wmask`=0, `o_rdata`=0xFFFF_FF80, one `o_rvalid` pulse.
- **HU / W lane select:** HU at 0x…0E with bytes[15:14]=0xBEEF → `o_rdata`=0x0000_BEEF. W at 0x…0C selects bytes[15:12].
- **SB mask and replication:** SB 0xA5 at 0x…03 → `o_mem_we`=1, `o_mem_wmask`=0x0008, `o_mem_wdata`=0xA5 ×16. No `o_rvalid`.
- **Backpressure:** hold `i_mem_ready`=0 for 5 cycles → `o_mem_valid` and outputs stable, `o_busy`=1 throughout, exactly one transaction.
- **Faults:** LW at 0x…02, and `i_ctrl`=011 → `o_fault` pulses once, `o_mem_valid` never rises, `o_busy` stays 0.
- **Reset mid-operation:** `RST_X`=0 during WAIT → all outputs at reset values immediately. A subsequent `i_mem_rvalid` produces no `o_rvalid`.

Source files
------------

// File: rtl/dmem_req_bridge.sv
// dmem_req_bridge
//    Data-side bridge from the core's scalar load/store port to a 128-bit,
//    line-oriented memory controller. One request is in flight at a time;
//    the core is stalled via o_busy until the transaction completes.
//
// State table
//    state   | meaning
//    IDLE    | waiting for a core request; illegal requests fault here
//    REQ     | line request presented on the memory bus, waiting for ready
//    WAIT    | load issued, waiting for the read line
//    DONE    | transaction complete; o_rvalid pulses for loads
//
// Ports
//    CLK, RST_X            clock, async active-low reset
//    i_req/i_we/i_addr     core request strobe, store flag, byte address
//    i_wdata/i_ctrl        right-aligned store data, size code
//    o_busy                core stall (combinational on i_req in IDLE)
//    o_rvalid/o_rdata      load completion pulse, extended load data
//    o_fault               pulse for misaligned or reserved-size request
//    o_mem_*/i_mem_*       valid/ready line request, read-data return
module dmem_req_bridge #(
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [2:0]        i_ctrl,
   output logic              o_busy,
   output logic              o_rvalid,
   output logic [31:0]       o_rdata,
   output logic              o_fault,
   output logic              o_mem_valid,
   input  logic              i_mem_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [127:0]      o_mem_wdata,
   output logic [15:0]       o_mem_wmask,
   input  logic              i_mem_rvalid,
   input  logic [127:0]      i_mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        ctrl_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              fault_q;
   logic              req_legal;
   logic [3:0]        off0, off1, off2, off3;
   logic [31:0]       lane;
   logic [31:0]       load_ext;

   always_comb begin
      req_legal = 1'b0;
      case (i_ctrl)
         3'b000, 3'b100: req_legal = 1'b1;
         3'b001, 3'b101: req_legal = ~i_addr[0];
         3'b010:         req_legal = (i_addr[1:0] == 2'b00);
         default:        req_legal = 1'b0;
      endcase
   end

   // Byte-wise lane pick with 4-bit wrapping offsets keeps every index in
   // range; wrap never matters because aligned accesses stay inside the line.
   assign off0 = addr_q[3:0];
   assign off1 = addr_q[3:0] + 4'd1;
   assign off2 = addr_q[3:0] + 4'd2;
   assign off3 = addr_q[3:0] + 4'd3;
   assign lane = {i_mem_rdata[{off3, 3'b000} +: 8], i_mem_rdata[{off2, 3'b000} +: 8],
                  i_mem_rdata[{off1, 3'b000} +: 8], i_mem_rdata[{off0, 3'b000} +: 8]};

   always_comb begin
      load_ext = lane;
      case (ctrl_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'h0, lane[7:0]};
         3'b101:  load_ext = {16'h0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state   <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         ctrl_q  <= 3'b000;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         fault_q <= 1'b0;
         if (state == ST_IDLE && i_req) begin
            if (req_legal) begin
               we_q    <= i_we;
               addr_q  <= i_addr;
               ctrl_q  <= i_ctrl;
               wdata_q <= i_wdata;
            end else begin
               fault_q <= 1'b1;
            end
         end
         if (state == ST_WAIT && i_mem_rvalid)
            rdata_q <= load_ext;
      end
   end

   always_comb begin
      state_nxt   = state;
      o_busy      = 1'b0;
      o_mem_valid = 1'b0;
      o_rvalid    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_req && req_legal) begin
               o_busy    = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            o_busy      = 1'b1;
            o_mem_valid = 1'b1;
            if (i_mem_ready)
               state_nxt = we_q ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            o_busy = 1'b1;
            if (i_mem_rvalid)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_rvalid  = ~we_q;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request fields come straight from the latched request so they are
   // stable for the whole REQ phase regardless of core-side activity.
   always_comb begin
      o_mem_wdata = {4{wdata_q}};
      o_mem_wmask = 16'h000F << addr_q[3:0];
      case (ctrl_q[1:0])
         2'b00: begin
            o_mem_wdata = {16{wdata_q[7:0]}};
            o_mem_wmask = 16'h0001 << addr_q[3:0];
         end
         2'b01: begin
            o_mem_wdata = {8{wdata_q[15:0]}};
            o_mem_wmask = 16'h0003 << addr_q[3:0];
         end
         default: begin
            o_mem_wdata = {4{wdata_q}};
            o_mem_wmask = 16'h000F << addr_q[3:0];
         end
      endcase
      if (!we_q)
         o_mem_wmask = 16'h0000;
   end

   assign o_mem_we   = we_q & (state == ST_REQ);
   assign o_mem_addr = {addr_q[ADDR_W-1:4], 4'b0000};
   assign o_rdata    = rdata_q;
   assign o_fault    = fault_q;

endmodule
